// File: rtl/chip8_rom_loader.sv
// CHIP-8 ROM loader: syncs SCK-domain download writes into clk, writes RAM,
// zero-fills the tail and holds the CPU in reset until the image is ready.
//
// Ports:
//   clk, reset_n                 system clock, async active-low reset
//   dl_downloading, dl_wr        SCK-domain download flag and byte strobe
//   dl_a[11:0], dl_d[7:0]        SCK-domain address/data (stable while dl_wr)
//   ram_we, ram_a, ram_d         single-cycle RAM write port
//   cpu_reset_n                  CPU reset, low while loading
//   loading                      high in LOAD or CLEAR
//   byte_count[12:0]             bytes accepted in current/last download
//   done                         one-clk pulse when the CPU is released
module chip8_rom_loader #(
  parameter logic [11:0] START_ADDR  = 12'h200,
  parameter bit          CLEAR_TAIL  = 1'b1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_downloading,
  input  logic        dl_wr,
  input  logic [11:0] dl_a,
  input  logic [7:0]  dl_d,
  output logic        ram_we,
  output logic [11:0] ram_a,
  output logic [7:0]  ram_d,
  output logic        cpu_reset_n,
  output logic        loading,
  output logic [12:0] byte_count,
  output logic        done
);

  typedef enum logic [1:0] {
    S_RUN,
    S_LOAD,
    S_CLEAR
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] dl_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic                   dl_q;
  logic                   wr_q;
  logic                   dl_s;
  logic                   wr_s;
  logic                   dl_rise;
  logic                   dl_fall;
  logic                   wr_rise;

  logic [12:0] next_addr, next_addr_n;
  logic [11:0] clr_ptr, clr_ptr_n;
  logic [12:0] byte_count_n;
  logic        ram_we_n;
  logic [11:0] ram_a_n;
  logic [7:0]  ram_d_n;
  logic        cpu_reset_n_n;
  logic        loading_n;
  logic        done_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_sync <= '0;
      wr_sync <= '0;
      dl_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      dl_sync <= {dl_sync[SYNC_STAGES-2:0], dl_downloading};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], dl_wr};
      dl_q    <= dl_sync[SYNC_STAGES-1];
      wr_q    <= wr_sync[SYNC_STAGES-1];
    end
  end

  assign dl_s    = dl_sync[SYNC_STAGES-1];
  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign dl_rise = dl_s & ~dl_q;
  assign dl_fall = ~dl_s & dl_q;
  assign wr_rise = wr_s & ~wr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RUN;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    next_addr_n  = next_addr;
    clr_ptr_n    = clr_ptr;
    byte_count_n = byte_count;
    ram_we_n     = 1'b0;
    ram_a_n      = ram_a;
    ram_d_n      = ram_d;
    unique case (state)
      S_RUN: begin
        if (dl_rise) begin
          state_n      = S_LOAD;
          byte_count_n = '0;
          next_addr_n  = {1'b0, START_ADDR};
        end
      end
      S_LOAD: begin
        if (wr_rise && (dl_a >= START_ADDR)) begin
          ram_we_n    = 1'b1;
          ram_a_n     = dl_a;
          ram_d_n     = dl_d;
          next_addr_n = {1'b0, dl_a} + 13'd1;
          if (byte_count != 13'h1000) begin
            byte_count_n = byte_count + 13'd1;
          end
        end
        // The fall sees next_addr including a write issued on this clk.
        if (dl_fall) begin
          if (CLEAR_TAIL && !next_addr_n[12]) begin
            state_n   = S_CLEAR;
            clr_ptr_n = next_addr_n[11:0];
          end else begin
            state_n = S_RUN;
          end
        end
      end
      S_CLEAR: begin
        if (dl_rise) begin
          state_n      = S_LOAD;
          byte_count_n = '0;
          next_addr_n  = {1'b0, START_ADDR};
        end else begin
          ram_we_n  = 1'b1;
          ram_a_n   = clr_ptr;
          ram_d_n   = 8'h00;
          clr_ptr_n = clr_ptr + 12'd1;
          if (clr_ptr == 12'hFFF) begin
            state_n = S_RUN;
          end
        end
      end
      default: state_n = S_RUN;
    endcase
    cpu_reset_n_n = (state_n == S_RUN);
    loading_n     = (state_n != S_RUN);
    done_n        = (state != S_RUN) && (state_n == S_RUN)
                    && !dl_rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_addr   <= 13'h0200;
      clr_ptr     <= '0;
      byte_count  <= '0;
      ram_we      <= 1'b0;
      ram_a       <= '0;
      ram_d       <= '0;
      cpu_reset_n <= 1'b0;
      loading     <= 1'b0;
      done        <= 1'b0;
    end else begin
      next_addr   <= next_addr_n;
      clr_ptr     <= clr_ptr_n;
      byte_count  <= byte_count_n;
      ram_we      <= ram_we_n;
      ram_a       <= ram_a_n;
      ram_d       <= ram_d_n;
      cpu_reset_n <= cpu_reset_n_n;
      loading     <= loading_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_chip8_rom_loader.sv
// Randomized bench for chip8_rom_loader against a RAM-image reference model.
// Drives SCK-domain downloads at clk/20 and checks RAM, counts and handshakes.
module tb_chip8_rom_loader;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_downloading = 1'b0;
  logic        dl_wr = 1'b0;
  logic [11:0] dl_a = '0;
  logic [7:0]  dl_d = '0;
  logic        ram_we;
  logic [11:0] ram_a;
  logic [7:0]  ram_d;
  logic        cpu_reset_n;
  logic        loading;
  logic [12:0] byte_count;
  logic        done;

  chip8_rom_loader #(
    .START_ADDR (12'h200),
    .CLEAR_TAIL (1'b1),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dl_downloading(dl_downloading),
    .dl_wr         (dl_wr),
    .dl_a          (dl_a),
    .dl_d          (dl_d),
    .ram_we        (ram_we),
    .ram_a         (ram_a),
    .ram_d         (ram_d),
    .cpu_reset_n   (cpu_reset_n),
    .loading       (loading),
    .byte_count    (byte_count),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] dut_ram [4096];
  logic [7:0] exp_ram [4096];
  int         wr_cnt = 0;
  int         done_cnt = 0;
  bit         hit400 = 1'b0;

  int qa[$];
  int qd[$];

  always @(negedge clk) begin
    if (ram_we) begin
      dut_ram[ram_a] = ram_d;
      wr_cnt++;
      if (ram_a == 12'h400) hit400 = 1'b1;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int a, input int d);
    dl_a  = a[11:0];
    dl_d  = d[7:0];
    dl_wr = 1'b1;
    clks(10);
    dl_wr = 1'b0;
    clks(10);
  endtask

  task automatic cmp_ram(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 4096; i++)
      if (dut_ram[i] !== exp_ram[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic wait_done(input string tag, input int d0, output int lat);
    lat = 0;
    while (done_cnt == d0 && lat < 6000) begin
      @(posedge clk);
      lat++;
    end
    #1;
    check({tag, "_done_seen"}, done_cnt - d0, 1);
  endtask

  // Reference: accepted bytes land in RAM; the tail from one past the
  // last accepted address to 0xFFF is zeroed unless that is past the end.
  task automatic run_download(input string tag, input bit do_cmp);
    int nx, cnt, writes, w0, d0, lat;
    nx = 'h200;
    cnt = 0;
    writes = 0;
    foreach (qa[i]) begin
      if (qa[i] >= 'h200) begin
        exp_ram[qa[i]] = qd[i][7:0];
        cnt++;
        writes++;
        nx = qa[i] + 1;
      end
    end
    for (int i = nx; i < 4096; i++) begin
      exp_ram[i] = 8'h00;
      writes++;
    end
    w0 = wr_cnt;
    d0 = done_cnt;
    dl_downloading = 1'b1;
    clks(20);
    check({tag, "_loading"}, {cpu_reset_n, loading}, 2'b01);
    foreach (qa[i]) send_byte(qa[i], qd[i]);
    check({tag, "_count_in_load"}, byte_count, cnt);
    dl_downloading = 1'b0;
    wait_done(tag, d0, lat);
    if (nx == 4096)
      check({tag, "_fast_release"}, (lat - 1 <= SYNC + 2), 1);
    clks(3);
    check({tag, "_writes"}, wr_cnt - w0, writes);
    check({tag, "_byte_count"}, byte_count, cnt);
    check({tag, "_released"}, {cpu_reset_n, loading}, 2'b10);
    check({tag, "_one_done"}, done_cnt - d0, 1);
    if (do_cmp) cmp_ram({tag, "_ram"});
    qa.delete();
    qd.delete();
  endtask

  initial begin
    int w0, d0, lat, a, d;
    for (int i = 0; i < 4096; i++) begin
      dut_ram[i] = 8'h00;
      exp_ram[i] = 8'h00;
    end

    #3;
    check("rst_outs", {ram_we, cpu_reset_n, loading, done}, 4'b0000);
    check("rst_addr", {ram_a, ram_d}, 20'h0);
    check("rst_count", byte_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_cpu", {cpu_reset_n, loading}, 2'b10);

    // Basic three-byte image with tail fill.
    qa = '{'h200, 'h201, 'h202};
    qd = '{'hAA, 'hBB, 'hCC};
    run_download("t1", 1'b1);

    // Font-area byte dropped, following byte accepted.
    qa = '{'h1FF, 'h200};
    qd = '{'h55, 'h66};
    run_download("t2", 1'b1);

    // Last byte at 0xFFF: no fill, fast release.
    qa = '{'h300, 'hFFF};
    qd = '{'h12, 'h34};
    run_download("t3", 1'b1);

    // Abort a fill with a new download.
    d0 = done_cnt;
    hit400 = 1'b0;
    dl_downloading = 1'b1;
    clks(20);
    dl_downloading = 1'b0;
    lat = 0;
    while (!hit400 && lat < 2000) begin
      @(posedge clk);
      lat++;
    end
    #1;
    check("t5_reach_400", hit400, 1);
    dl_downloading = 1'b1;
    clks(10);
    w0 = wr_cnt;
    clks(30);
    check("t5_we_stopped", wr_cnt - w0, 0);
    check("t5_state", {cpu_reset_n, loading}, 2'b01);
    check("t5_count", byte_count, 0);
    check("t5_no_done", done_cnt - d0, 0);
    d = $urandom_range(0, 255);
    send_byte('hFFF, d);
    check("t5_write_fff", wr_cnt - w0, 1);
    check("t5_data_fff", dut_ram['hFFF], d);
    exp_ram['hFFF] = d[7:0];
    dl_downloading = 1'b0;
    wait_done("t5", d0, lat);
    clks(3);

    // Empty download: full fill, also resyncs the partially filled area.
    run_download("t4", 1'b1);

    // Reset in the middle of a load.
    w0 = wr_cnt;
    dl_downloading = 1'b1;
    clks(20);
    d = $urandom_range(0, 255);
    send_byte('h250, d);
    exp_ram['h250] = d[7:0];
    check("t6_mid_load", {cpu_reset_n, loading, byte_count}, {2'b01, 13'd1});
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async", {ram_we, cpu_reset_n, loading}, 3'b000);
    check("t6_count", byte_count, 0);
    dl_downloading = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_release", {cpu_reset_n, loading}, 2'b10);
    clks(5);
    check("t6_writes", wr_cnt - w0, 1);
    cmp_ram("t6_ram");

    // Random downloads mixing font-area, mid-range and top-of-RAM bytes.
    for (int k = 0; k < 5; k++) begin
      int n;
      n = $urandom_range(0, 5);
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 2))
          0:       a = $urandom_range(0, 'h1FF);
          1:       a = $urandom_range('h200, 'hFEF);
          default: a = $urandom_range('hFF0, 'hFFF);
        endcase
        qa.push_back(a);
        qd.push_back($urandom_range(0, 255));
      end
      run_download($sformatf("rnd%0d", k), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
